// File: rtl/snoop_hazard_gate.sv
// snoop_hazard_gate
// Read-side hazard gate beside a snoopable write FIFO. A single read request
// is held, snooped against the queued writes, and forwarded downstream only
// once no write matches. Each match costs a fixed back-off and another snoop.
// After MAX_RETRY matches the request is forced out with out_hazard set.
// Every output is driven from a register, so there is no input-to-output path.

module snoop_hazard_gate #(
  parameter int DW        = 40,
  parameter int BACKOFF   = 4,
  parameter int MAX_RETRY = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] req_data,
  input  logic          req_valid,
  output logic          req_ready,
  output logic [DW-1:0] sdata,
  output logic          svalid,
  input  logic          smatch,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_hazard,
  output logic [7:0]    retry_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  localparam logic [7:0] LP_MAX_RETRY  = 8'(MAX_RETRY);
  localparam logic [7:0] LP_BACKOFF_LD = 8'(BACKOFF - 1);

  state_t          r_state;
  logic [DW-1:0]   r_hold;
  logic [7:0]      r_retry;
  logic [7:0]      r_backoff;
  logic            r_req_ready;
  logic            r_svalid;
  logic            r_out_valid;
  logic            r_hazard;

  logic [7:0]      w_retry_next;
  logic            w_retry_exhausted;

  // Saturating retry increment and the forced-issue decision for a matching snoop
  always_comb begin
    w_retry_next      = r_retry;
    w_retry_exhausted = 1'b0;
    if (r_retry < LP_MAX_RETRY) begin
      w_retry_next = r_retry + 8'd1;
    end else begin
      w_retry_next = LP_MAX_RETRY;
    end
    if (w_retry_next >= LP_MAX_RETRY) begin
      w_retry_exhausted = 1'b1;
    end else begin
      w_retry_exhausted = 1'b0;
    end
  end

  // Gate FSM: state, held request, retry/back-off counters and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hold      <= {DW{1'b0}};
      r_retry     <= 8'd0;
      r_backoff   <= 8'd0;
      r_req_ready <= 1'b1;
      r_svalid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_hazard    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_hold      <= req_data;
            r_retry     <= 8'd0;
            r_req_ready <= 1'b0;
            r_svalid    <= 1'b1;
            r_state     <= ST_SNOOP;
          end
        end
        ST_SNOOP: begin
          // smatch is only meaningful here, while svalid is high
          r_svalid <= 1'b0;
          if (!smatch) begin
            r_hazard    <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end else if (!w_retry_exhausted) begin
            r_retry   <= w_retry_next;
            r_backoff <= LP_BACKOFF_LD;
            r_state   <= ST_WAIT;
          end else begin
            r_retry     <= w_retry_next;
            r_hazard    <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          // Counter loaded with BACKOFF-1, so WAIT spans exactly BACKOFF cycles
          if (r_backoff == 8'd0) begin
            r_svalid <= 1'b1;
            r_state  <= ST_SNOOP;
          end else begin
            r_backoff <= r_backoff - 8'd1;
          end
        end
        ST_ISSUE: begin
          // retry_cnt is left alone so it still describes the last request
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_hazard    <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_svalid    <= 1'b0;
          r_out_valid <= 1'b0;
          r_hazard    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign svalid     = r_svalid;
  assign sdata      = r_hold;
  assign out_valid  = r_out_valid;
  assign out_data   = r_hold;
  assign out_hazard = r_hazard;
  assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_snoop_hazard_gate.sv
// Scoreboard bench for snoop_hazard_gate: directed stimulus pushes the
// expected forwarded request; monitors check snoops and output handshakes.

module tb_snoop_hazard_gate;

  localparam int DW = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] req_data;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] sdata;
  logic          svalid;
  logic          smatch;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_hazard;
  logic [7:0]    retry_cnt;

  snoop_hazard_gate #(.DW(DW), .BACKOFF(4), .MAX_RETRY(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .sdata      (sdata),
    .svalid     (svalid),
    .smatch     (smatch),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hazard (out_hazard),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          haz;
    logic [7:0]    retry;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            snoop_idx = 0;
  int            match_n   = 0;
  int            last_out_cyc = 0;
  int            prev_out_cyc = 0;
  logic [DW-1:0] tb_hold = '0;

  // FIFO model: the first match_n snoops of each request report a match
  assign smatch = svalid && (snoop_idx < match_n);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic h, input logic [7:0] r);
    exp_t e;
    e.data  = d;
    e.haz   = h;
    e.retry = r;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 300) begin
      step();
      n++;
    end
    chk("wait_req_ready", req_ready, 1);
  endtask

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Track accepted request and snoop index from the input side
  always @(posedge clk) begin
    if (rst) begin
      snoop_idx <= 0;
    end else if (req_valid && req_ready) begin
      snoop_idx <= 0;
      tb_hold   <= req_data;
    end else if (svalid) begin
      snoop_idx <= snoop_idx + 1;
    end
  end

  // Snoop monitor: sdata must carry the accepted request
  always @(negedge clk) begin
    if (!rst && svalid) chk("snoop_sdata", sdata, tb_hold);
  end

  // Output monitor: pop and compare on every downstream handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out got=%0h expected=none", out_data);
      end else begin
        chk("out_data", out_data, sb[0].data);
        chk("out_hazard", out_hazard, sb[0].haz);
        chk("retry_cnt", retry_cnt, sb[0].retry);
        sb.pop_front();
      end
      prev_out_cyc <= last_out_cyc;
      last_out_cyc <= cyc;
    end
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] va;
    logic [DW-1:0] vb;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_data  = '0;
    out_ready = 1'b1;
    match_n   = 0;
    repeat (3) step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_svalid", svalid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_hazard", out_hazard, 0);
    chk("rst_retry_cnt", retry_cnt, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    step();

    // 1: no match, forwarded two cycles after accept
    va = 40'h12_3456_789A;
    push(va, 1'b0, 8'd0);
    req_data  = va;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("t1_svalid", svalid, 1);
    chk("t1_sdata", sdata, va);
    chk("t1_out_valid_early", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_svalid_off", svalid, 0);
    step();
    chk("t1_req_ready_back", req_ready, 1);

    // 2: two matches, snoops at T+1, T+6, T+11 and issue at T+12
    wait_ready();
    va = 40'hA5_0000_0002;
    match_n = 2;
    push(va, 1'b0, 8'd2);
    req_data  = va;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk("t2_svalid", svalid, (k == 1 || k == 6 || k == 11));
      chk("t2_out_valid", out_valid, (k == 12));
      if (k < 12) step();
    end
    step();

    // 3: always matching, forced issue after 15 snoops
    wait_ready();
    va = 40'h33_CAFE_0003;
    match_n = 1000;
    push(va, 1'b1, 8'd15);
    req_data  = va;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    chk("t3_out_valid", out_valid, 1);
    chk("t3_snoop_count", snoop_idx, 15);
    chk("t3_hazard", out_hazard, 1);
    chk("t3_retry", retry_cnt, 15);
    step();
    match_n = 0;

    // 4: downstream stall, second request waits for the handshake
    wait_ready();
    va = 40'h44_0000_00AA;
    vb = 40'h44_0000_00BB;
    out_ready = 1'b0;
    push(va, 1'b0, 8'd0);
    req_data  = va;
    req_valid = 1'b1;
    step();
    req_data = vb;
    step();
    for (int k = 0; k < 10; k++) begin
      chk("t4_out_valid", out_valid, 1);
      chk("t4_out_data", out_data, va);
      chk("t4_req_ready", req_ready, 0);
      step();
    end
    push(vb, 1'b0, 8'd0);
    out_ready = 1'b1;
    step();
    chk("t4_req_ready_after", req_ready, 1);
    chk("t4_out_valid_after", out_valid, 0);
    step();
    chk("t4_b_svalid", svalid, 1);
    req_valid = 1'b0;
    repeat (3) step();

    // 5: reset during WAIT drops the request
    wait_ready();
    va = 40'h55_DEAD_0005;
    match_n = 1000;
    req_data  = va;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("t5_retry_in_wait", retry_cnt, 1);
    chk("t5_svalid_in_wait", svalid, 0);
    rst = 1'b1;
    step();
    chk("t5_req_ready", req_ready, 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_retry", retry_cnt, 0);
    chk("t5_svalid", svalid, 0);
    rst = 1'b0;
    match_n = 0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) n++;
      step();
    end
    chk("t5_no_out_pulse", n, 0);

    // 6: back-to-back requests, outputs three cycles apart
    wait_ready();
    va = 40'h66_0000_000A;
    vb = 40'h66_0000_000B;
    push(va, 1'b0, 8'd0);
    req_data  = va;
    req_valid = 1'b1;
    step();
    push(vb, 1'b0, 8'd0);
    req_data = vb;
    step();
    step();
    chk("t6_req_ready", req_ready, 1);
    step();
    chk("t6_b_svalid", svalid, 1);
    req_valid = 1'b0;
    repeat (3) step();
    chk("t6_spacing", last_out_cyc - prev_out_cyc, 3);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
